flot_div_sched: RTL and testbench
=================================

// Module: flot_div_sched
// PURPOSE
//  Shares one pipelined float divider (flot_Divide_pipe family) between N_REQ requesters.
//  Arbitrates issue slots round-robin and tags every operation with its requester index.
//  Carries the tags through a shadow pipeline matched to the divider latency.
//  Steers each result back to its owner.
//  Stalls the divider through its CE input when the owner of the emerging result is not ready.
// PARAMETERS
//  WIDTH    32  float word width (sign+exp+mantissa)
//  N_REQ    4   number of requesters (2..8)
//  TAG_W    2   tag width, = clog2(N_REQ)
//  DIV_LAT  8   divider latency in CE-enabled cycles, OP1/OP2 in -> result out
// PORTS
//  CLK           in   1            clock, rising edge
//  RST           in   1            asynchronous reset, active-high
//  req_valid     in   N_REQ        request pending, one bit per requester
//  req_op1       in   N_REQ*WIDTH  dividend, requester i at [i*WIDTH +: WIDTH]
//  req_op2       in   N_REQ*WIDTH  divisor, same packing
//  req_exce      in   N_REQ        exception-in flag per requester
//  req_ready     out  N_REQ        one-hot grant; handshake done when valid&ready
//  div_nRST      out  1            divider reset, = ~RST
//  div_CE        out  1            divider clock enable
//  div_OP1       out  WIDTH        operand to divider
//  div_OP2       out  WIDTH        operand to divider
//  div_exce_in   out  1            exception-in to divider
//  div_result    in   WIDTH        divider result
//  div_exce_out  in   1            divider exception-out
//  rsp_valid     out  N_REQ        one-hot; result for requester i present
//  rsp_ready     in   N_REQ        requester i accepts its result
//  rsp_result    out  WIDTH        = div_result whenever any rsp_valid is high
//  rsp_exce      out  1            = div_exce_out
//  in_flight     out  4            valid ops in the tag pipe (0..DIV_LAT)
// BEHAVIOUR
//  - Reset (async): tag pipe valid bits = 0, rr pointer = 0, in_flight = 0.
//    With no valid tail: rsp_valid = 0, req_ready = 0, div_CE = 1.
//  - RST mid-operation drops every in-flight op. The divider is also reset through div_nRST.
//    No rsp_valid is raised for dropped ops.
//  - Tag pipe: DIV_LAT stages of {v, tag}. It shifts only when div_CE = 1.
//    Stage 0 loads {issue, grant_idx}. The tail is stage DIV_LAT-1.
//  - Stall: stall = tail.v & ~rsp_ready[tail.tag]. div_CE = ~stall (combinational).
//  - Arbitration (combinational): grant the first i with req_valid[i], scanning ptr, ptr+1, ...
//    with wrap-around modulo N_REQ. req_ready = onehot(grant) & {N_REQ{div_CE}}.
//  - Issue: issue = |(req_valid & req_ready).
//    On issue: div_OP1/OP2/exce_in = the granted requester's fields, and ptr <= grant_idx+1 (wraps).
//    No issue: div_OP1 = div_OP2 = 0, div_exce_in = 0, stage 0 loads v = 0 (bubble).
//  - Response: rsp_valid = tail.v ? onehot(tail.tag) : 0. It is held stable while stalled.
//    The result retires on the edge where div_CE = 1.
//  - in_flight: count of v bits. Incremented on issue, decremented on retire.
//    Both in one cycle -> unchanged. It never exceeds DIV_LAT.
//  - Throughput: 1 op/cycle when unstalled.
//    Latency request-accept -> rsp_valid = DIV_LAT cycles plus stall cycles.
//  - Ordering: results return in issue order. Per-requester order is preserved.
//  - Stalled cycle: no grant, no shift, ptr unchanged, and div_OP* are don't-care because the divider is frozen.
//  - req_valid dropped before handshake: legal. No op is issued for it.
// TESTING
//  1. Single op: req 0 sends 0x40C00000 / 0x40000000 (6.0/2.0).
//     -> req_ready[0] in the same cycle; rsp_valid = 0001 with rsp_result = 0x40400000 exactly DIV_LAT cycles later.
//  2. All 4 requesters valid for 8 cycles, rsp_ready = 1111.
//     -> grants 0,1,2,3,0,1,2,3; responses in that order back-to-back; in_flight peaks at 8.
//  3. Backpressure: req 2 result at the tail with rsp_ready[2] = 0 for 5 cycles.
//     -> div_CE = 0, rsp_valid = 0100 held, req_ready = 0 for 5 cycles; no result lost or duplicated.
//  4. Wrap-around fairness: ptr = 3, req_valid = 1001.
//     -> grant 3, then grant 0, then 3; a requester never waits more than N_REQ-1 grants.
//  5. Exception: req 1 issues with req_exce = 1 (operand 0x00000000 divisor).
//     -> rsp_valid = 0010 with rsp_exce = div_exce_out = 1.
//  6. Reset mid-flight: RST pulsed with 5 ops in flight.
//     -> rsp_valid = 0 immediately; in_flight = 0; no stale response after release; next grant goes to req 0.

Source files
------------

// File: rtl/flot_div_sched.sv
// rtl/flot_div_sched.sv - round-robin scheduler sharing one pipelined float divider
// Tags each issued op with its requester, tracks tags alongside the divider, steers results back.
module flot_div_sched #(
   parameter int WIDTH   = 32,
   parameter int N_REQ   = 4,
   parameter int TAG_W   = 2,
   parameter int DIV_LAT = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_op1,
   input  logic [N_REQ*WIDTH-1:0] req_op2,
   input  logic [N_REQ-1:0]       req_exce,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   div_nRST,
   output logic                   div_CE,
   output logic [WIDTH-1:0]       div_OP1,
   output logic [WIDTH-1:0]       div_OP2,
   output logic                   div_exce_in,
   input  logic [WIDTH-1:0]       div_result,
   input  logic                   div_exce_out,
   output logic [N_REQ-1:0]       rsp_valid,
   input  logic [N_REQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]       rsp_result,
   output logic                   rsp_exce,
   output logic [3:0]             in_flight
);
   localparam logic [TAG_W:0]   NREQ_W = (TAG_W+1)'(N_REQ);
   localparam logic [N_REQ-1:0] ONE    = N_REQ'(1);

   logic [DIV_LAT-1:0] pipe_v;
   logic [TAG_W-1:0]   pipe_tag [DIV_LAT];
   logic [TAG_W-1:0]   ptr;
   logic               tail_v;
   logic [TAG_W-1:0]   tail_tag;
   logic               stall;
   logic               issue;
   logic               retire;
   logic               grant_found;
   logic [TAG_W-1:0]   grant_idx;

   assign tail_v   = pipe_v[DIV_LAT-1];
   assign tail_tag = pipe_tag[DIV_LAT-1];
   assign stall    = tail_v & ~rsp_ready[tail_tag];
   assign div_CE   = ~stall;
   assign retire   = tail_v & div_CE;
   assign div_nRST = ~RST;

   assign rsp_valid  = tail_v ? (ONE << tail_tag) : '0;
   assign rsp_result = div_result;
   assign rsp_exce   = div_exce_out;

   // Scan from ptr upward with wrap; first pending requester wins
   always_comb begin
      logic [TAG_W:0] scan;
      grant_found = 1'b0;
      grant_idx   = '0;
      scan        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan = {1'b0, ptr} + (TAG_W+1)'(k);
         if (scan >= NREQ_W) scan = scan - NREQ_W;
         if (!grant_found && req_valid[scan[TAG_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan[TAG_W-1:0];
         end
      end
   end

   assign issue     = grant_found & div_CE;
   assign req_ready = issue ? (ONE << grant_idx) : '0;

   always_comb begin
      div_OP1     = '0;
      div_OP2     = '0;
      div_exce_in = 1'b0;
      if (issue) begin
         div_OP1     = req_op1[int'(grant_idx)*WIDTH +: WIDTH];
         div_OP2     = req_op2[int'(grant_idx)*WIDTH +: WIDTH];
         div_exce_in = req_exce[grant_idx];
      end
   end

   // Tag pipe advances in lockstep with the divider's CE
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pipe_v    <= '0;
         ptr       <= '0;
         in_flight <= '0;
         for (int s = 0; s < DIV_LAT; s++) pipe_tag[s] <= '0;
      end else begin
         if (div_CE) begin
            pipe_v      <= {pipe_v[DIV_LAT-2:0], issue};
            pipe_tag[0] <= grant_idx;
            for (int s = 1; s < DIV_LAT; s++) pipe_tag[s] <= pipe_tag[s-1];
         end
         if (issue)
            ptr <= (grant_idx == TAG_W'(N_REQ-1)) ? '0 : grant_idx + TAG_W'(1);
         case ({issue, retire})
            2'b10:   in_flight <= in_flight + 4'd1;
            2'b01:   in_flight <= in_flight - 4'd1;
            default: in_flight <= in_flight;
         endcase
      end
   end
endmodule

// File: tb/tb_flot_div_sched.sv
// tb/tb_flot_div_sched.sv - scoreboard bench for flot_div_sched with a behavioural divider
module tb_flot_div_sched;
   localparam int W = 32;
   localparam int N = 4;
   localparam int L = 8;

   logic           CLK = 1'b0;
   logic           RST;
   logic [N-1:0]   req_valid, req_exce, req_ready, rsp_valid, rsp_ready;
   logic [N*W-1:0] req_op1, req_op2;
   logic           div_nRST, div_CE, div_exce_in, div_exce_out, rsp_exce;
   logic [W-1:0]   div_OP1, div_OP2, div_result, rsp_result;
   logic [3:0]     in_flight;

   flot_div_sched #(.WIDTH(W), .N_REQ(N), .TAG_W(2), .DIV_LAT(L)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2), .req_exce(req_exce),
      .req_ready(req_ready),
      .div_nRST(div_nRST), .div_CE(div_CE), .div_OP1(div_OP1), .div_OP2(div_OP2),
      .div_exce_in(div_exce_in), .div_result(div_result), .div_exce_out(div_exce_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_exce(rsp_exce), .in_flight(in_flight)
   );

   always #5 CLK = ~CLK;

   // Exponent-field subtraction: exact for divisors with unit mantissa (6.0/2.0 -> 3.0)
   function automatic logic [W-1:0] fdiv(input logic [W-1:0] a, input logic [W-1:0] b);
      return a - b + 32'h3F80_0000;
   endfunction

   logic [W-1:0] d_res [L];
   logic         d_exc [L];
   always @(posedge CLK or negedge div_nRST) begin
      if (!div_nRST) begin
         for (int s = 0; s < L; s++) begin
            d_res[s] <= '0;
            d_exc[s] <= 1'b0;
         end
      end else if (div_CE) begin
         d_res[0] <= fdiv(div_OP1, div_OP2);
         d_exc[0] <= div_exce_in | (div_OP2 == '0);
         for (int s = 1; s < L; s++) begin
            d_res[s] <= d_res[s-1];
            d_exc[s] <= d_exc[s-1];
         end
      end
   end
   assign div_result   = d_res[L-1];
   assign div_exce_out = d_exc[L-1];

   int n_chk = 0;
   int n_err = 0;
   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endfunction

   function automatic int rr(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int           idx;
      logic [W-1:0] res;
      logic         exc;
      int           cyc;
      int           stl;
   } exp_t;
   exp_t q[$];
   int ptr_m = 0;
   int stall_cnt = 0;
   int peak = 0;

   always @(negedge CLK) begin
      logic         stall_o;
      logic [N-1:0] exp_rv, exp_rr, hs;
      int           g;
      exp_t         e;
      if (RST) begin
         chk("rst_rsp_valid", 64'(rsp_valid), 0);
         chk("rst_in_flight", 64'(in_flight), 0);
         q.delete();
         ptr_m = 0;
      end else begin
         stall_o = (rsp_valid != 0) && ((rsp_valid & rsp_ready) == 0);
         exp_rv = '0;
         if (q.size() > 0 && (cyc - q[0].cyc) == (L + stall_cnt - q[0].stl))
            exp_rv = N'(1) << q[0].idx;
         chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
         chk("in_flight", 64'(in_flight), 64'(q.size()));
         chk("div_CE", 64'(div_CE), 64'(!stall_o));
         exp_rr = '0;
         if (!stall_o) begin
            g = rr(req_valid, ptr_m);
            if (g >= 0) exp_rr = N'(1) << g;
         end
         chk("req_ready", 64'(req_ready), 64'(exp_rr));
         if ((rsp_valid & rsp_ready) != 0) begin
            if (q.size() == 0) begin
               chk("stale_rsp", 64'(rsp_valid), 0);
            end else begin
               e = q.pop_front();
               chk("rsp_result", 64'(rsp_result), 64'(e.res));
               chk("rsp_exce", 64'(rsp_exce), 64'(e.exc));
            end
         end
         hs = req_valid & req_ready;
         if (hs != 0) begin
            g = 0;
            for (int i = N - 1; i >= 0; i--) if (hs[i]) g = i;
            e.idx = g;
            e.res = fdiv(req_op1[g*W +: W], req_op2[g*W +: W]);
            e.exc = req_exce[g] | (req_op2[g*W +: W] == '0);
            e.cyc = cyc;
            e.stl = stall_cnt;
            q.push_back(e);
            ptr_m = (g + 1) % N;
         end
         if (stall_o) stall_cnt++;
         if (int'(in_flight) > peak) peak = int'(in_flight);
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         req_op1[i*W +: W] = $urandom;
         req_op2[i*W +: W] = $urandom;
      end
      req_exce = N'($urandom);
   endtask

   task automatic wait_rsp();
      int k;
      k = 0;
      while (rsp_valid == 0 && k < 30) begin
         @(negedge CLK);
         k++;
      end
      if (k >= 30) chk("rsp_timeout", 64'(k), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0;
      RST = 1'b1; req_valid = '0; req_op1 = '0; req_op2 = '0; req_exce = '0; rsp_ready = '1;
      @(negedge CLK);
      chk("reset_req_ready", 64'(req_ready), 0);
      chk("reset_div_CE", 64'(div_CE), 1);
      repeat (2) step();
      RST = 1'b0;

      // single op 6.0 / 2.0
      req_valid = 4'b0001;
      req_op1[0 +: W] = 32'h40C0_0000;
      req_op2[0 +: W] = 32'h4000_0000;
      @(negedge CLK);
      chk("t1_ready", 64'(req_ready), 64'h1);
      t0 = cyc;
      step();
      req_valid = '0;
      wait_rsp();
      chk("t1_latency", 64'(cyc - t0), 64'(L));
      chk("t1_valid", 64'(rsp_valid), 64'h1);
      chk("t1_result", 64'(rsp_result), 64'h4040_0000);
      step();

      // all four requesters for eight cycles
      peak = 0;
      for (int c = 0; c < 8; c++) begin
         rand_ops();
         req_valid = 4'b1111;
         step();
      end
      req_valid = '0;
      repeat (12) step();
      chk("t2_peak", 64'(peak), 64'(L));

      // backpressure on requester 2
      rsp_ready = 4'b1011;
      rand_ops();
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      wait_rsp();
      for (int j = 0; j < 5; j++) begin
         chk("t3_ce", 64'(div_CE), 0);
         chk("t3_ready", 64'(req_ready), 0);
         chk("t3_hold", 64'(rsp_valid), 64'h4);
         step();
         req_valid = 4'b1111;
         @(negedge CLK);
      end
      step();
      rsp_ready = 4'b1111;
      req_valid = '0;
      repeat (12) step();

      // wrap-around: ptr to 3, then 1001
      req_valid = 4'b0100;
      step();
      req_valid = 4'b1001;
      @(negedge CLK); chk("t4_g3a", 64'(req_ready), 64'h8);
      step();
      @(negedge CLK); chk("t4_g0", 64'(req_ready), 64'h1);
      step();
      @(negedge CLK); chk("t4_g3b", 64'(req_ready), 64'h8);
      step();
      req_valid = '0;
      repeat (12) step();

      // exception from requester 1
      req_op1[1*W +: W] = '0;
      req_op2[1*W +: W] = '0;
      req_exce = 4'b0010;
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      wait_rsp();
      chk("t5_valid", 64'(rsp_valid), 64'h2);
      chk("t5_exce", 64'(rsp_exce), 1);
      repeat (3) step();

      // reset with five ops in flight
      for (int c = 0; c < 5; c++) begin
         rand_ops();
         req_valid = 4'b1111;
         step();
      end
      req_valid = '0;
      chk("t6_pre_inflight", 64'(in_flight), 5);
      RST = 1'b1;
      #1;
      chk("t6_rsp_valid", 64'(rsp_valid), 0);
      chk("t6_inflight", 64'(in_flight), 0);
      repeat (2) step();
      RST = 1'b0;
      req_valid = 4'b1111;
      @(negedge CLK);
      chk("t6_grant0", 64'(req_ready), 64'h1);
      step();
      req_valid = '0;
      repeat (12) step();

      // randomized traffic with random backpressure
      for (int c = 0; c < 1500; c++) begin
         rand_ops();
         req_valid = N'($urandom);
         for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(3) != 0);
         step();
      end
      req_valid = '0;
      rsp_ready = '1;
      repeat (20) step();
      chk("final_empty", 64'(q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
